// File: rtl/assoc_buffer_pkg.sv
// assoc_buffer_pkg: opcodes, FSM state encoding and small helpers shared by
// assoc_buffer_arbiter and its bench-facing users.
package assoc_buffer_pkg;

    // Buffer command opcodes as driven on ctrl.
    localparam int OP_NOP    = 0;
    localparam int OP_INSERT = 1;
    localparam int OP_LOOKUP = 2;
    localparam int OP_REMOVE = 3;

    // Command sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    // Width of a down-counter that must hold latency-1; never narrower than 1 bit.
    function automatic int wait_count_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/assoc_buffer_arbiter_rr_picker.sv
// rr_picker: combinational two-way grant selection for assoc_buffer_arbiter.
// Default build is round-robin on ties; defining ASSOC_BUFFER_ARB_FIXED_PRIO_EN
// makes requester 0 win every tie and the last-grant input is then ignored.
module rr_picker (
    input  logic req0_valid_i,
    input  logic req1_valid_i,
    input  logic last_grant_i,   // requester granted most recently (1 = requester 1)
    output logic any_valid_o,
    output logic grant_o         // winner: 0 = requester 0, 1 = requester 1
);

    // Pick a winner from the current valids; a lone requester always wins.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        any_valid_o = req0_valid_i | req1_valid_i;
        grant_o     = 1'b0;
`ifdef ASSOC_BUFFER_ARB_FIXED_PRIO_EN
        grant_o = ~req0_valid_i;
`else
        if (req0_valid_i && req1_valid_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req1_valid_i;
        end
`endif
    end

`ifdef ASSOC_BUFFER_ARB_FIXED_PRIO_EN
    // Fixed priority has no use for the previous grant.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/assoc_buffer_arbiter.sv
// assoc_buffer_arbiter: lets two requesters share the single command port of
// associative_buffer. One command is in flight at a time:
//   IDLE -> ISSUE (one-cycle command + ack) -> WAIT (BUF_LATENCY cycles) -> RESPOND
// A NOP skips the buffer and goes IDLE -> RESPOND with ack and response together.
// Build option: ASSOC_BUFFER_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties) instead of round-robin.
module assoc_buffer_arbiter
    import assoc_buffer_pkg::*;
#(
    parameter int KEY_WIDTH   = 2,
    parameter int DATA_WIDTH  = 4,
    parameter int CTRL_WIDTH  = 2,
    parameter int BUF_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [KEY_WIDTH-1:0]  req0_key,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ack,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp0_hit,

    input  logic                  req1_valid,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [KEY_WIDTH-1:0]  req1_key,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ack,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  resp1_hit,

    output logic [CTRL_WIDTH-1:0] buf_ctrl,
    output logic [KEY_WIDTH-1:0]  buf_key,
    output logic [DATA_WIDTH-1:0] buf_data,
    input  logic [DATA_WIDTH-1:0] buf_data_output,
    input  logic                  buf_valid
);

    localparam int                   CNT_WIDTH = wait_count_width(BUF_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(BUF_LATENCY - 1);

    // Sequencer state and command latches.
    arb_state_t            state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    // Requester served by the current/most recent command. It routes the
    // response and doubles as the round-robin last-grant history.
    logic                  grant_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CTRL_WIDTH-1:0] buf_ctrl_q;

    // Registered requester-facing outputs.
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  resp0_valid_q;
    logic                  resp1_valid_q;
    logic [DATA_WIDTH-1:0] resp0_data_q;
    logic [DATA_WIDTH-1:0] resp1_data_q;
    logic                  resp0_hit_q;
    logic                  resp1_hit_q;

    // Arbitration result and the winner's payload, valid while in IDLE.
    logic                  any_valid_d;
    logic                  grant_d;
    logic [CTRL_WIDTH-1:0] ctrl_d;
    logic [KEY_WIDTH-1:0]  key_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  is_nop_d;

    rr_picker u_picker (
        .req0_valid_i (req0_valid),
        .req1_valid_i (req1_valid),
        .last_grant_i (grant_q),
        .any_valid_o  (any_valid_d),
        .grant_o      (grant_d)
    );

    // Steer the winning requester's payload toward the latches.
    always_comb begin
        ctrl_d = req0_ctrl;
        key_d  = req0_key;
        data_d = req0_data;
        if (grant_d) begin
            ctrl_d = req1_ctrl;
            key_d  = req1_key;
            data_d = req1_data;
        end
    end

    assign is_nop_d = (ctrl_d == CTRL_WIDTH'(OP_NOP));

    // Command sequencer: arbitration, one-cycle issue, latency wait, response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= 1'b1;   // requester 0 wins the first tie
            key_q         <= '0;
            data_q        <= '0;
            buf_ctrl_q    <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
            resp0_hit_q   <= 1'b0;
            resp1_hit_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse defaults below
            // are overridden by any later assignment in the same cycle.
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (any_valid_d) begin
                        grant_q <= grant_d;
                        key_q   <= key_d;
                        data_q  <= data_d;
                        if (grant_d) begin
                            ack1_q <= 1'b1;
                        end else begin
                            ack0_q <= 1'b1;
                        end
                        if (is_nop_d) begin
                            // Nothing goes to the buffer: answer with zeros right away.
                            if (grant_d) begin
                                resp1_valid_q <= 1'b1;
                                resp1_data_q  <= '0;
                                resp1_hit_q   <= 1'b0;
                            end else begin
                                resp0_valid_q <= 1'b1;
                                resp0_data_q  <= '0;
                                resp0_hit_q   <= 1'b0;
                            end
                            state_q <= RESPOND;
                        end else begin
                            buf_ctrl_q <= ctrl_d;
                            state_q    <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    buf_ctrl_q <= '0;
                    cnt_q      <= CNT_LOAD;
                    state_q    <= WAIT;
                end

                WAIT: begin
                    if (cnt_q == '0) begin
                        if (grant_q) begin
                            resp1_valid_q <= 1'b1;
                            resp1_data_q  <= buf_data_output;
                            resp1_hit_q   <= buf_valid;
                        end else begin
                            resp0_valid_q <= 1'b1;
                            resp0_data_q  <= buf_data_output;
                            resp0_hit_q   <= buf_valid;
                        end
                        state_q <= RESPOND;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                RESPOND: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_data  = resp0_data_q;
    assign resp1_data  = resp1_data_q;
    assign resp0_hit   = resp0_hit_q;
    assign resp1_hit   = resp1_hit_q;
    assign buf_ctrl    = buf_ctrl_q;
    assign buf_key     = key_q;
    assign buf_data    = data_q;

endmodule

// File: tb/tb_assoc_buffer_arbiter.sv
// tb_assoc_buffer_arbiter: scoreboard bench for assoc_buffer_arbiter with a
// behavioural associative buffer attached to the buf_* port.
module tb_assoc_buffer_arbiter;

    localparam int KW = 2;
    localparam int DW = 4;
    localparam int CW = 2;
    localparam int L  = 2;

    localparam int OP_NOP    = 0;
    localparam int OP_INSERT = 1;
    localparam int OP_LOOKUP = 2;
    localparam int OP_REMOVE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [CW-1:0] req_ctrl [2];
    logic [KW-1:0] req_key  [2];
    logic [DW-1:0] req_data [2];

    logic          ack0, ack1, rv0, rv1, rh0, rh1;
    logic [DW-1:0] rd0, rd1;
    logic [CW-1:0] buf_ctrl;
    logic [KW-1:0] buf_key;
    logic [DW-1:0] buf_data;
    logic [DW-1:0] buf_data_output = '0;
    logic          buf_valid = 1'b0;

    assoc_buffer_arbiter #(
        .KEY_WIDTH(KW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUF_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ctrl(req_ctrl[0]), .req0_key(req_key[0]),
        .req0_data(req_data[0]), .req0_ack(ack0), .resp0_valid(rv0),
        .resp0_data(rd0), .resp0_hit(rh0),
        .req1_valid(req_valid[1]), .req1_ctrl(req_ctrl[1]), .req1_key(req_key[1]),
        .req1_data(req_data[1]), .req1_ack(ack1), .resp1_valid(rv1),
        .resp1_data(rd1), .resp1_hit(rh1),
        .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data(buf_data),
        .buf_data_output(buf_data_output), .buf_valid(buf_valid)
    );

    initial forever #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int     id;
        int     op;
        int     key;
        int     wdata;
        int     data;
        int     hit;
        longint cyc;
    } exp_t;
    exp_t sb[$];

    // Reference contents of the associative buffer, as the requesters see it.
    int ref_mem [4];
    bit ref_val [4];

    task automatic ref_exec(input int op, input int k, input int d, output int rd, output int rh);
        rd = 0;
        rh = 0;
        case (op)
            OP_INSERT: begin ref_mem[k] = d; ref_val[k] = 1'b1; rd = d; rh = 1; end
            OP_LOOKUP: begin rd = ref_mem[k]; rh = int'(ref_val[k]); end
            OP_REMOVE: begin rd = ref_mem[k]; rh = int'(ref_val[k]); ref_val[k] = 1'b0; end
            default: ;
        endcase
    endtask

    // ---------------- buffer model ----------------
    // Applies a command in the cycle buf_ctrl is nonzero; its answer is visible
    // only in the cycle exactly L later, with noise on every other cycle.
    int bmem [4];
    bit bval [4];
    initial begin
        longint pend_cyc;
        int     pd, ph, k;
        pend_cyc = -1;
        pd = 0;
        ph = 0;
        for (int i = 0; i < 4; i++) begin bmem[i] = 0; bval[i] = 1'b0; ref_mem[i] = 0; ref_val[i] = 1'b0; end
        forever begin
            @(negedge clk);
            if (buf_ctrl != '0) begin
                k = int'(buf_key);
                case (int'(buf_ctrl))
                    OP_INSERT: begin bmem[k] = int'(buf_data); bval[k] = 1'b1; pd = bmem[k]; ph = 1; end
                    OP_LOOKUP: begin pd = bmem[k]; ph = int'(bval[k]); end
                    default:   begin pd = bmem[k]; ph = int'(bval[k]); bval[k] = 1'b0; end
                endcase
                pend_cyc = cyc + L;
            end
            if (cyc == pend_cyc) begin
                buf_data_output = DW'(pd);
                buf_valid       = ph[0];
            end else begin
                buf_data_output = DW'($urandom);
                buf_valid       = 1'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [1:0] s_ack, s_rv, s_val, s_rh, prev_ack;
        int         s_rd [2];
        int         ld [2];
        int         lh [2];
        int         s_bc, s_bk, s_bd;
        logic       s_rst;
        longint     s_cyc;
        exp_t       e;
        prev_ack = '0;
        ld[0] = 0; ld[1] = 0; lh[0] = 0; lh[1] = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_ack = {ack1, ack0}; s_rv = {rv1, rv0}; s_rh = {rh1, rh0};
            s_rd[0] = int'(rd0); s_rd[1] = int'(rd1); s_val = req_valid;
            s_bc = int'(buf_ctrl); s_bk = int'(buf_key); s_bd = int'(buf_data); s_cyc = cyc;
            #2;
            if (!s_rst) begin
                prev_ack = '0;
                ld[0] = 0; ld[1] = 0; lh[0] = 0; lh[1] = 0;
            end else begin
                if (s_bc != 0) check("buf_ctrl_only_with_ack", s_ack != 2'b00, 1);
                for (int r = 0; r < 2; r++) begin
                    if (s_ack[r]) begin
                        check("ack_single_cycle", prev_ack[r], 0);
                        check("ack_has_valid", s_val[r], 1);
                    end
                    if (s_rv[r]) begin
                        check("resp_expected", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("resp_requester", r, e.id);
                            check("resp_data", s_rd[r], e.data);
                            check("resp_hit", s_rh[r], e.hit);
                            check("resp_cycle", s_cyc, e.cyc);
                            if (e.op != OP_NOP) begin
                                check("buf_key_held", s_bk, e.key);
                                check("buf_data_held", s_bd, e.wdata);
                            end
                        end
                        ld[r] = s_rd[r];
                        lh[r] = int'(s_rh[r]);
                    end else begin
                        check("resp_data_hold", s_rd[r], ld[r]);
                        check("resp_hit_hold", s_rh[r], lh[r]);
                    end
                end
                prev_ack = s_ack;
            end
        end
    end

    // ---------------- driver ----------------
    bit pend [2];
    int p_op [2];
    int p_key [2];
    int p_dat [2];
    int last_win = 1;

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = pend[r];
            req_ctrl[r]  = CW'(p_op[r]);
            req_key[r]   = KW'(p_key[r]);
            req_data[r]  = DW'(p_dat[r]);
        end
    endtask

    task automatic arm(input int r, input int op, input int k, input int d);
        pend[r] = 1'b1; p_op[r] = op; p_key[r] = k; p_dat[r] = d;
    endtask

    function automatic int rand_op();
        int x;
        x = int'($urandom_range(0, 7));
        return (x == 0) ? OP_NOP : ((x < 4) ? OP_INSERT : ((x < 7) ? OP_LOOKUP : OP_REMOVE));
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_sb_empty();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Present pending requests, wait for the ack, predict and record the outcome.
    task automatic contest(input bit from_idle);
        bit     got;
        int     w, pred, rd, rh;
        longint start, a;
        exp_t   e;
        drive_reqs();
        start = cyc;
        got = 1'b0;
        w = 0;
        a = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got = 1'b1;
                w = ack1 ? 1 : 0;
                a = cyc;
            end
        end
        check("ack_seen", got, 1);
        if (!got) begin
            #1;
            pend[0] = 1'b0; pend[1] = 1'b0;
            drive_reqs();
            return;
        end
        if (pend[0] && pend[1]) begin
`ifdef ASSOC_BUFFER_ARB_FIXED_PRIO_EN
            pred = 0;
`else
            pred = 1 - last_win;
`endif
        end else begin
            pred = pend[1] ? 1 : 0;
        end
        check("grant", w, pred);
        if (from_idle) check("ack_latency", a, start + 1);
        if (p_op[w] == OP_NOP) begin
            check("nop_buf_ctrl", buf_ctrl, 0);
        end else begin
            check("issue_buf_ctrl", buf_ctrl, p_op[w]);
            check("issue_buf_key", buf_key, p_key[w]);
            check("issue_buf_data", buf_data, p_dat[w]);
        end
        ref_exec(p_op[w], p_key[w], p_dat[w], rd, rh);
        e.id = w; e.op = p_op[w]; e.key = p_key[w]; e.wdata = p_dat[w];
        e.data = rd; e.hit = rh;
        e.cyc = (p_op[w] == OP_NOP) ? a : a + L + 1;
        sb.push_back(e);
        last_win = w;
        pend[w] = 1'b0;
        #1;
        drive_reqs();
    endtask

    task automatic do_cmd(input int r, input int op, input int k, input int d);
        wait_sb_empty();
        wait_cycles(1);
        arm(r, op, k, d);
        contest(1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && (pend[0] || pend[1]); i++) contest(1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_resp0_valid"}, rv0, 0);
        check({tag, "_resp1_valid"}, rv1, 0);
        check({tag, "_resp0_data"}, rd0, 0);
        check({tag, "_resp1_data"}, rd1, 0);
        check({tag, "_resp0_hit"}, rh0, 0);
        check({tag, "_resp1_hit"}, rh1, 0);
        check({tag, "_buf_ctrl"}, buf_ctrl, 0);
        check({tag, "_buf_key"}, buf_key, 0);
        check({tag, "_buf_data"}, buf_data, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit got;
        int expect_grant;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_op[r] = 0; p_key[r] = 0; p_dat[r] = 0;
        end
        drive_reqs();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        rst = 1'b1;

        // Single INSERT then LOOKUP from requester 0.
        do_cmd(0, OP_INSERT, 2, 5);
        do_cmd(0, OP_LOOKUP, 2, 0);
        // NOP from requester 1: ack and response in the same cycle.
        do_cmd(1, OP_NOP, 1, 3);

        // Both requesters busy for four commands: grants alternate (or stay 0).
        wait_sb_empty();
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r]) arm(r, OP_LOOKUP, int'($urandom_range(0, 3)), 0);
`ifdef ASSOC_BUFFER_ARB_FIXED_PRIO_EN
            expect_grant = 0;
`else
            expect_grant = i % 2;
`endif
            contest(1'b0);
            check("alternating_grant", last_win, expect_grant);
        end
        drain();

        // Requester 0 withdraws during RESPOND of requester 1's command.
        do_cmd(1, OP_LOOKUP, 2, 0);
        arm(0, OP_INSERT, 1, 9);
        arm(1, OP_LOOKUP, 1, 0);
        drive_reqs();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rv1) got = 1'b1;
        end
        check("drop_resp_seen", got, 1);
        #1;
        pend[0] = 1'b0;
        contest(1'b0);
        check("drop_grant", last_win, 1);

        // Reset during WAIT abandons the command.
        do_cmd(0, OP_LOOKUP, 2, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("mid_reset");
        sb.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_reqs();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        last_win = 1;
        wait_cycles(8);
        arm(0, OP_INSERT, 3, 7);
        arm(1, OP_INSERT, 0, 4);
        contest(1'b1);
        check("post_reset_grant", last_win, 0);
        drain();

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 2) != 0)
                    arm(r, rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            if (!pend[0] && !pend[1])
                arm(int'($urandom_range(0, 1)), rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) wait_cycles(int'($urandom_range(1, 3)));
            contest(1'b0);
        end
        drain();
        wait_sb_empty();
        wait_cycles(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
